ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter PC_W, default 13: program counter and operand width.
REQ-002 Parameter RESET_PC, default 0: PC value loaded at reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 run  input  1  start request; sampled only in IDLE.
REQ-006 mem_req  output  1  instruction-memory read request.
REQ-007 mem_addr  output  PC_W  read address; equals current PC while mem_req=1.
REQ-008 mem_ack  input  1  read complete; mem_rdata valid in the same cycle.
REQ-009 mem_rdata  input  16  instruction word: [15:13] major opcode, [12:0] operand or [12:8] sub-op.
REQ-010 op  output  8  decoder opcode byte.
REQ-011 op_valid  output  1  op/operand valid; high exactly one cycle per instruction.
REQ-012 operand  output  PC_W  ir[PC_W-1:0] of the issued instruction.
REQ-013 pc_mode  input  3  decoder's PC mode for the issued op, combinational, sampled while op_valid=1.
REQ-014 pc  output  PC_W  current program counter.
REQ-015 halted  output  1  high in HALT state.

Function
REQ-016 FSM states: IDLE, FETCH, ISSUE, HALT; exactly one state active.
REQ-017 IDLE: all request/valid outputs low; run=1 -> FETCH next cycle; run=0 -> stay.
REQ-018 FETCH: mem_req=1, mem_addr=pc; on mem_ack=1: ir <= mem_rdata, go to ISSUE; mem_ack=0 -> stay, hold mem_req high.
REQ-019 mem_ack outside FETCH is ignored.
REQ-020 ISSUE: op_valid=1 for one cycle; mem_req=0.
REQ-021 op decode: ir[15:13]==cu_long_begin -> op={ir[15:13], ir[12:8]}; otherwise op={ir[15:13], 5'b00000}.
REQ-022 ISSUE, pc_mode=pc_mode_normal -> pc <= pc+1 mod 2^PC_W; go to FETCH.
REQ-023 ISSUE, pc_mode=pc_mode_jump -> pc <= ir[PC_W-1:0]; go to FETCH.
REQ-024 ISSUE, pc_mode=pc_mode_stop or any unassigned code -> pc unchanged; go to HALT.
REQ-025 HALT: halted=1; stays until rst; run ignored.
REQ-026 PC increment from 2^PC_W-1 wraps to 0 without error.
REQ-027 Minimum throughput: 2 cycles per instruction when mem_ack is high in the first FETCH cycle.
REQ-028 op and operand hold their last issued value outside ISSUE; only op_valid qualifies them.

Reset
REQ-029 rst=1 at any clock edge, in any state including mid-FETCH: state <= IDLE, pc <= RESET_PC, ir <= 0.
REQ-030 Output values during and after reset: mem_req=0, op_valid=0, op=0, operand=0, halted=0, mem_addr=pc=RESET_PC.
REQ-031 rst has priority over run, mem_ack, and pc_mode in the same cycle.

Structure
REQ-032 pc_mode_normal=3'b000, pc_mode_jump=3'b001, pc_mode_stop=3'b010 and cu_long_begin=3'b111 come from the shared define file; no local copies.
REQ-033 FSM state encodings are local to ifu.
REQ-034 No sub-module; the op-byte formation is a combinational function of ir inside ifu.

Verification
REQ-035 Reset then run=1, mem_ack tied high, words 0x0005, 0x2003 at addresses 0,1, decoder returns normal -> op 0x00 then 0x20, op_valid pulses at cycles 3 and 5, pc 0->1->2.
REQ-036 Word 0xE300 (long, sub-op 0x03) -> op=0xE3; word 0xE000 -> op=0xE0.
REQ-037 Jump: word 0x6010 at address 2, pc_mode=jump -> next mem_addr=0x0010.
REQ-038 mem_ack delayed 4 cycles -> mem_req held high and mem_addr stable for all 4 cycles; op_valid=0 throughout.
REQ-039 pc=0x1FFF, pc_mode=normal -> next mem_addr=0x0000; pc_mode=stop -> halted=1, mem_req stays 0, run pulses ignored.
REQ-040 rst asserted mid-FETCH with mem_ack=1 in the same cycle -> IDLE, pc=0, op_valid never pulses.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared defines for the fetch unit and its decoder.
// PC-mode codes and the long-opcode major value.
package ifu_pkg;

  localparam int IW = 16;

  localparam logic [2:0] pc_mode_normal = 3'b000;
  localparam logic [2:0] pc_mode_jump   = 3'b001;
  localparam logic [2:0] pc_mode_stop   = 3'b010;

  localparam logic [2:0] cu_long_begin  = 3'b111;

  typedef logic [IW-1:0] iword_t;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: fetch a word, issue one op,
// advance/jump/stop the PC from the decoder's pc_mode.
module ifu
  import ifu_pkg::*;
#(
  parameter int             PC_W     = 13,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [15:0]     mem_rdata,
  output logic [7:0]      op,
  output logic            op_valid,
  output logic [PC_W-1:0] operand,
  input  logic [2:0]      pc_mode,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [1:0] {
    s_idle,
    s_fetch,
    s_issue,
    s_halt
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  iword_t          ir_q, ir_d;

  // Long ops carry a sub-op in [12:8]; others use only the major.
  function automatic logic [7:0] op_byte(input iword_t w);
    if (w[15:13] == cu_long_begin)
      return w[15:8];
    return {w[15:13], 5'b00000};
  endfunction

  // Next state, next PC and instruction capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      s_idle: begin
        if (run)
          state_d = s_fetch;
      end
      s_fetch: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = s_issue;
        end
      end
      s_issue: begin
        unique case (pc_mode)
          pc_mode_normal: begin
            pc_d    = pc_q + PC_W'(1);
            state_d = s_fetch;
          end
          pc_mode_jump: begin
            pc_d    = PC_W'(ir_q);
            state_d = s_fetch;
          end
          default: state_d = s_halt;
        endcase
      end
      s_halt: state_d = s_halt;
      default: state_d = s_idle;
    endcase
  end

  // State, PC and IR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= s_idle;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign mem_req  = (state_q == s_fetch);
  assign mem_addr = pc_q;
  assign op_valid = (state_q == s_issue);
  assign op       = op_byte(ir_q);
  assign operand  = PC_W'(ir_q);
  assign pc       = pc_q;
  assign halted   = (state_q == s_halt);

endmodule

// File: tb/tb_ifu.sv
// Randomized transaction-level bench for ifu against a
// reference model of PC flow and op-byte formation.
module tb_ifu;

  localparam int PC_W = 13;

  logic            clk = 1'b0;
  logic            rst;
  logic            run;
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [15:0]     mem_rdata;
  logic [7:0]      op;
  logic            op_valid;
  logic [PC_W-1:0] operand;
  logic [2:0]      pc_mode;
  logic [PC_W-1:0] pc;
  logic            halted;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;

  logic [PC_W-1:0] mpc;
  logic [7:0]      last_op;

  ifu #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .op       (op),
    .op_valid (op_valid),
    .operand  (operand),
    .pc_mode  (pc_mode),
    .pc       (pc),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (op_valid) pulses++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [15:0] w);
    int major;
    major = int'(w[15:13]);
    if (major == 7)
      return 8'(major * 32 + int'(w[12:8]));
    return 8'(major * 32);
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".mem_req"}, 32'(mem_req), 0);
    chk({tag, ".op_valid"}, 32'(op_valid), 0);
    chk({tag, ".op"}, 32'(op), 0);
    chk({tag, ".operand"}, 32'(operand), 0);
    chk({tag, ".halted"}, 32'(halted), 0);
    chk({tag, ".pc"}, 32'(pc), 0);
    chk({tag, ".mem_addr"}, 32'(mem_addr), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0;
    pc_mode = 3'b000; mem_rdata = '0;
    cyc(); cyc();
    chk_reset_outs("rst");
    rst = 1'b0;
    mpc = '0;
    last_op = '0;
  endtask

  task automatic start_run();
    int n;
    run = 1'b1;
    cyc();
    run = 1'b0;
    n = 0;
    while (!mem_req && n < 8) begin
      cyc();
      n++;
    end
    chk("wait_fetch", 32'(mem_req), 1);
  endtask

  // One instruction: optional ack delay, issue, pc_mode reply.
  task automatic fetch_issue(input logic [15:0] word,
                             input int delay,
                             input logic [2:0] mode);
    chk("f.mem_req", 32'(mem_req), 1);
    chk("f.mem_addr", 32'(mem_addr), 32'(mpc));
    chk("f.op_hold", 32'(op), 32'(last_op));
    for (int i = 0; i < delay; i++) begin
      mem_ack = 1'b0;
      mem_rdata = 16'($urandom);
      cyc();
      chk("w.mem_req", 32'(mem_req), 1);
      chk("w.mem_addr", 32'(mem_addr), 32'(mpc));
      chk("w.op_valid", 32'(op_valid), 0);
    end
    mem_ack = 1'b1;
    mem_rdata = word;
    cyc();
    mem_ack = 1'b0;
    exp_pulses++;
    chk("i.op_valid", 32'(op_valid), 1);
    chk("i.mem_req", 32'(mem_req), 0);
    chk("i.op", 32'(op), 32'(ref_op(word)));
    chk("i.operand", 32'(operand), 32'(word) % 8192);
    last_op = ref_op(word);
    pc_mode = mode;
    cyc();
    pc_mode = 3'($urandom);
    chk("n.op_valid", 32'(op_valid), 0);
    if (mode == 3'd0) begin
      mpc = PC_W'((int'(mpc) + 1) % 8192);
    end else if (mode == 3'd1) begin
      mpc = PC_W'(int'(word) % 8192);
    end else begin
      chk("h.halted", 32'(halted), 1);
      chk("h.pc", 32'(pc), 32'(mpc));
    end
  endtask

  initial begin
    do_reset();
    mem_ack = 1'b1;
    cyc(); cyc();
    chk("idle.mem_req", 32'(mem_req), 0);
    chk("idle.ack_ignored", 32'(op_valid), 0);
    mem_ack = 1'b0;

    start_run();
    fetch_issue(16'h0005, 0, 3'b000);
    fetch_issue(16'h2003, 0, 3'b000);
    chk("seq.pc2", 32'(pc), 2);
    fetch_issue(16'h6010, 0, 3'b001);
    chk("jump.addr", 32'(mem_addr), 32'h10);
    fetch_issue(16'hE300, 4, 3'b000);
    fetch_issue(16'hE000, 0, 3'b000);

    for (int k = 0; k < 60; k++) begin
      logic [15:0] w;
      w = 16'($urandom);
      fetch_issue(w, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 3'b001 : 3'b000);
    end

    fetch_issue(16'h3FFF, 0, 3'b001);
    chk("top.addr", 32'(mem_addr), 32'h1FFF);
    fetch_issue(16'($urandom), 0, 3'b000);
    chk("wrap.addr", 32'(mem_addr), 0);
    fetch_issue(16'h4000, 0, 3'b010);
    for (int k = 0; k < 6; k++) begin
      run = k[0];
      mem_ack = 1'b1;
      cyc();
      chk("halt.halted", 32'(halted), 1);
      chk("halt.mem_req", 32'(mem_req), 0);
      chk("halt.op_valid", 32'(op_valid), 0);
      chk("halt.pc", 32'(pc), 32'(mpc));
    end
    run = 1'b0;
    mem_ack = 1'b0;

    do_reset();
    start_run();
    fetch_issue(16'h1234, 1, 3'b000);
    fetch_issue(16'hA055, 0, 3'($urandom_range(3, 7)));

    do_reset();
    start_run();
    mem_ack = 1'b0;
    cyc();
    chk("mid.mem_req", 32'(mem_req), 1);
    rst = 1'b1;
    run = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 16'hE7FF;
    pc_mode = 3'b001;
    cyc();
    chk_reset_outs("midrst");
    rst = 1'b0;
    run = 1'b0;
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("after.op_valid", 32'(op_valid), 0);
      chk("after.mem_req", 32'(mem_req), 0);
    end
    mem_ack = 1'b0;

    chk("pulse_count", 32'(pulses), 32'(exp_pulses));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
